// File: rtl/fb_pkg.sv
// Shared framebuffer constants and the grant / clear-state encodings used by
// the port arbiter and its bench.
package fb_pkg;
  localparam int FB_AW    = 16;
  localparam int FB_DW    = 12;
  localparam int FB_WORDS = 57344;

  typedef enum logic [1:0] {GNT_IDLE, GNT_RD, GNT_WR, GNT_CLR} grant_e;
  typedef enum logic {CLR_IDLE, CLR_FILL} clr_state_e;
endpackage

// File: rtl/fb_port_arbiter_if.sv
// Requester-side bundle of the framebuffer arbiter: scanout reads, capture
// writes and the clear-engine control. master = requesters, slave = arbiter.
interface fb_port_arbiter_if #(
  parameter int AW = fb_pkg::FB_AW,
  parameter int DW = fb_pkg::FB_DW
);
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_ack;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          clear_start;
  logic [DW-1:0] clear_color;
  logic          clear_busy;
  logic          clear_done;

  modport master (
    output rd_req, rd_addr, wr_valid, wr_addr, wr_data, clear_start, clear_color,
    input  rd_ack, rd_valid, rd_data, wr_ready, clear_busy, clear_done
  );

  modport slave (
    input  rd_req, rd_addr, wr_valid, wr_addr, wr_data, clear_start, clear_color,
    output rd_ack, rd_valid, rd_data, wr_ready, clear_busy, clear_done
  );
endinterface

// File: rtl/fb_wr_fifo.sv
// Small synchronous FIFO buffering capture writes. The head entry is visible
// combinationally so the arbiter can issue it in the same cycle it pops.
module fb_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 28
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW:0]   count_reg;
  logic          do_push;
  logic          do_pop;

  assign full      = (count_reg == FULL_CNT);
  assign empty     = (count_reg == '0);
  assign count     = count_reg;
  assign head_data = mem[rd_ptr_reg];

  // A full FIFO refuses pushes even when it pops in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer arbiter: one RAM access per cycle shared between
// scanout reads, buffered capture writes and a constant-colour clear engine.
module fb_port_arbiter
  import fb_pkg::*;
#(
  parameter int AW          = FB_AW,
  parameter int DW          = FB_DW,
  parameter int WFIFO_DEPTH = 4,
  parameter int MAX_RD_RUN  = 8,
  parameter int CLEAR_LAST  = FB_WORDS - 1
) (
  input  logic           clk,
  input  logic           reset,
  fb_port_arbiter_if.slave bus,
  output logic [AW-1:0]  ram_addr,
  output logic           ram_we,
  output logic [DW-1:0]  ram_wdata,
  input  logic [DW-1:0]  ram_rdata
);
  localparam int CW = $clog2(WFIFO_DEPTH) + 1;
  localparam int RW = $clog2(MAX_RD_RUN + 1);
  localparam logic [CW-1:0] FIFO_FULL_CNT = CW'(WFIFO_DEPTH);
  localparam logic [RW-1:0] RUN_MAX       = RW'(MAX_RD_RUN);
  localparam logic [AW-1:0] CLR_LAST_A    = AW'(CLEAR_LAST);

  grant_e        grant;
  logic [AW+DW-1:0] fifo_head;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;

  logic          rd_valid_reg;
  logic [RW-1:0] rd_run_reg;
  clr_state_e    clr_state_reg;
  logic [AW-1:0] clr_addr_reg;
  logic [DW-1:0] clr_color_reg;
  logic          clr_done_reg;

  fb_wr_fifo #(
    .DEPTH (WFIFO_DEPTH),
    .W     (AW + DW)
  ) u_wr_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.wr_valid && bus.wr_ready),
    .push_data ({bus.wr_addr, bus.wr_data}),
    .pop       (grant == GNT_WR),
    .head_data (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head_addr = fifo_head[AW+DW-1:DW];
  assign head_data = fifo_head[DW-1:0];

  // Writes jump the read queue when the FIFO is full or reads have had their run.
  always_comb begin
    grant = GNT_IDLE;
    if (fifo_full || (!fifo_empty && rd_run_reg == RUN_MAX)) grant = GNT_WR;
    else if (bus.rd_req)                                     grant = GNT_RD;
    else if (!fifo_empty)                                    grant = GNT_WR;
    else if (clr_state_reg == CLR_FILL)                      grant = GNT_CLR;
  end

  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    case (grant)
      GNT_RD: ram_addr = bus.rd_addr;
      GNT_WR: begin
        ram_addr  = head_addr;
        ram_we    = 1'b1;
        ram_wdata = head_data;
      end
      GNT_CLR: begin
        ram_addr  = clr_addr_reg;
        ram_we    = 1'b1;
        ram_wdata = clr_color_reg;
      end
      default: ;
    endcase
  end

  assign bus.rd_ack     = (grant == GNT_RD);
  assign bus.rd_valid   = rd_valid_reg;
  assign bus.rd_data    = ram_rdata;
  assign bus.wr_ready   = (fifo_count < FIFO_FULL_CNT);
  assign bus.clear_busy = (clr_state_reg == CLR_FILL);
  assign bus.clear_done = clr_done_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid_reg <= 1'b0;
      rd_run_reg   <= '0;
    end else begin
      rd_valid_reg <= (grant == GNT_RD);
      // Only reads that overtake a pending write count towards the run limit.
      if (grant == GNT_WR || fifo_empty)
        rd_run_reg <= '0;
      else if (grant == GNT_RD && rd_run_reg != RUN_MAX)
        rd_run_reg <= rd_run_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_state_reg <= CLR_IDLE;
      clr_addr_reg  <= '0;
      clr_color_reg <= '0;
      clr_done_reg  <= 1'b0;
    end else begin
      clr_done_reg <= 1'b0;
      case (clr_state_reg)
        CLR_IDLE: begin
          if (bus.clear_start) begin
            clr_state_reg <= CLR_FILL;
            clr_addr_reg  <= '0;
            clr_color_reg <= bus.clear_color;
          end
        end
        CLR_FILL: begin
          if (grant == GNT_CLR) begin
            if (clr_addr_reg == CLR_LAST_A) begin
              clr_state_reg <= CLR_IDLE;
              clr_done_reg  <= 1'b1;
            end else begin
              clr_addr_reg <= clr_addr_reg + 1'b1;
            end
          end
        end
        default: clr_state_reg <= CLR_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed scenarios plus a random phase, all checked every cycle against a
// queue-based reference model of the arbitration rules and a RAM shadow.
module tb_fb_port_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [11:0] ram_wdata;
  logic [11:0] ram_rdata;

  fb_port_arbiter_if #(.AW(16), .DW(12)) bus ();

  fb_port_arbiter #(.CLEAR_LAST(15)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  // Framebuffer RAM: synchronous, one-cycle read latency.
  logic [11:0] ram [0:65535];
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: pending writes as a queue, plain ints for the rest.
  typedef struct packed {logic [15:0] a; logic [11:0] d;} wr_t;
  wr_t         q[$];
  int          run, m_caddr, m_g;
  bit          m_busy, m_done, m_rdv, m_rdknown;
  logic [11:0] m_color, m_rdexp;
  logic [11:0] ref_mem [int];

  int          n_we, n_ack, n_done, n_busy, n_ready_low;
  logic        o_ack, o_we;
  logic [11:0] rd_seen[$];

  task automatic model_reset();
    q.delete();
    run = 0; m_busy = 0; m_caddr = 0; m_done = 0; m_rdv = 0; m_color = '0; m_g = 0;
  endtask

  task automatic clear_counters();
    n_we = 0; n_ack = 0; n_done = 0; n_busy = 0; n_ready_low = 0;
    rd_seen.delete();
  endtask

  task automatic idle_inputs();
    bus.rd_req = 0; bus.rd_addr = '0; bus.wr_valid = 0; bus.wr_addr = '0;
    bus.wr_data = '0; bus.clear_start = 0; bus.clear_color = '0;
  endtask

  // 0 idle, 1 read, 2 fifo write, 3 clear write
  function automatic int exp_grant();
    if (q.size() == 4 || (q.size() > 0 && run == 8)) return 2;
    if (bus.rd_req)   return 1;
    if (q.size() > 0) return 2;
    if (m_busy)       return 3;
    return 0;
  endfunction

  // Called right after a falling edge with inputs already driven.
  task automatic step();
    int g, sz;
    logic [15:0] ea;
    logic [11:0] ed;
    #1;
    g = exp_grant();
    ea = '0; ed = '0;
    if (g == 1) ea = bus.rd_addr;
    else if (g == 2) begin ea = q[0].a; ed = q[0].d; end
    else if (g == 3) begin ea = 16'(m_caddr); ed = m_color; end
    chk("rd_ack",     32'(bus.rd_ack),     32'(g == 1));
    chk("ram_we",     32'(ram_we),         32'(g >= 2));
    chk("ram_addr",   32'(ram_addr),       32'(ea));
    if (g >= 2) chk("ram_wdata", 32'(ram_wdata), 32'(ed));
    chk("wr_ready",   32'(bus.wr_ready),   32'(q.size() < 4));
    chk("clear_busy", 32'(bus.clear_busy), 32'(m_busy));
    chk("clear_done", 32'(bus.clear_done), 32'(m_done));
    chk("rd_valid",   32'(bus.rd_valid),   32'(m_rdv));
    if (m_rdv && m_rdknown) chk("rd_data", 32'(bus.rd_data), 32'(m_rdexp));

    o_ack = bus.rd_ack; o_we = ram_we;
    if (ram_we)          n_we++;
    if (bus.rd_ack)      n_ack++;
    if (bus.clear_done)  n_done++;
    if (bus.clear_busy)  n_busy++;
    if (!bus.wr_ready)   n_ready_low++;
    if (bus.rd_valid)    rd_seen.push_back(bus.rd_data);
    if (ram_we)     $display("[%0t] ram write addr=%h data=%h", $time, ram_addr, ram_wdata);
    if (bus.rd_valid) $display("[%0t] read return data=%h", $time, bus.rd_data);

    if (reset) begin
      model_reset();
    end else begin
      sz = q.size();
      m_rdknown = 0;
      if (g == 1) begin
        m_rdknown = ref_mem.exists(int'(bus.rd_addr));
        if (m_rdknown) m_rdexp = ref_mem[int'(bus.rd_addr)];
      end
      m_rdv = (g == 1);
      if (g == 2) begin ref_mem[int'(q[0].a)] = q[0].d; void'(q.pop_front()); end
      if (g == 3) ref_mem[m_caddr] = m_color;
      if (g == 2 || sz == 0) run = 0;
      else if (g == 1 && run < 8) run++;
      if (bus.wr_valid && sz < 4) q.push_back({bus.wr_addr, bus.wr_data});
      m_done = 0;
      if (m_busy) begin
        if (g == 3) begin
          if (m_caddr == 15) begin m_busy = 0; m_done = 1; end
          else m_caddr++;
        end
      end else if (bus.clear_start) begin
        m_busy = 1; m_caddr = 0; m_color = bus.clear_color;
      end
      m_g = g;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] wa [5];
    logic [11:0] wd [5];
    int acks_before, we_at, ack_after;
    wa = '{16'h0010, 16'h0011, 16'h0012, 16'h0020, 16'h0021};
    wd = '{12'hABC, 12'h123, 12'h456, 12'h7A5, 12'h05A};

    reset = 1'b1;
    idle_inputs();
    model_reset();
    clear_counters();
    @(negedge clk);
    step();
    chk("rst_rd_valid",   32'(bus.rd_valid),   32'd0);
    chk("rst_wr_ready",   32'(bus.wr_ready),   32'd1);
    chk("rst_clear_busy", 32'(bus.clear_busy), 32'd0);
    chk("rst_clear_done", 32'(bus.clear_done), 32'd0);
    chk("rst_ram_we",     32'(ram_we),         32'd0);
    reset = 1'b0;
    step();

    // Write only: each write retires the cycle after acceptance.
    clear_counters();
    for (int i = 0; i < 5; i++) begin
      bus.wr_valid = 1; bus.wr_addr = wa[i]; bus.wr_data = wd[i];
      step();
    end
    idle_inputs();
    repeat (3) step();
    chk("wo_we_cycles",  32'(n_we),        32'd5);
    chk("wo_ready_drop", 32'(n_ready_low), 32'd0);
    for (int i = 0; i < 5; i++) chk("wo_ram_content", 32'(ram[wa[i]]), 32'(wd[i]));

    // Read only: three back-to-back reads.
    clear_counters();
    for (int i = 0; i < 3; i++) begin
      bus.rd_req = 1; bus.rd_addr = wa[i];
      step();
    end
    idle_inputs();
    repeat (3) step();
    chk("ro_acks",  32'(n_ack),          32'd3);
    chk("ro_we",    32'(n_we),           32'd0);
    chk("ro_count", 32'(rd_seen.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < rd_seen.size()) chk("ro_data", 32'(rd_seen[i]), 32'(wd[i]));

    // Starvation guard: one write pending under continuous reads.
    bus.rd_req = 1; bus.rd_addr = 16'h0040;
    step(); step();
    bus.wr_valid = 1; bus.wr_addr = 16'h0050; bus.wr_data = 12'hE1E;
    step();
    bus.wr_valid = 0;
    acks_before = 0; we_at = -1; ack_after = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (we_at < 0 && o_we) we_at = k;
      else if (we_at < 0 && o_ack) acks_before++;
      else if (we_at >= 0 && k == we_at + 1) ack_after = int'(o_ack);
    end
    chk("starve_reads",   32'(acks_before), 32'd8);
    chk("starve_wr_cyc",  32'(we_at),       32'd9);
    chk("starve_resume",  32'(ack_after),   32'd1);
    chk("starve_landed",  32'(ram[16'h0050]), 32'hE1E);
    idle_inputs();
    repeat (3) step();

    // FIFO full: four pushes under continuous reads.
    bus.rd_req = 1; bus.rd_addr = 16'h0041;
    for (int i = 0; i < 4; i++) begin
      bus.wr_valid = 1; bus.wr_addr = 16'(16'h0060 + i); bus.wr_data = 12'(12'h100 + i);
      step();
    end
    bus.wr_valid = 0;
    chk("full_ready_low", 32'(bus.wr_ready), 32'd0);
    step();
    chk("full_wr_grant", 32'(o_we),  32'd1);
    chk("full_no_ack",   32'(o_ack), 32'd0);
    chk("full_ready_up", 32'(bus.wr_ready), 32'd1);
    repeat (40) step();
    idle_inputs();
    repeat (3) step();

    // Clear fill of 16 words; a second start mid-fill is ignored.
    clear_counters();
    bus.clear_start = 1; bus.clear_color = 12'hF00;
    step();
    bus.clear_start = 0;
    repeat (3) step();
    bus.clear_start = 1; bus.clear_color = 12'h0F0;
    step();
    bus.clear_start = 0;
    repeat (22) step();
    chk("clr_writes", 32'(n_we),   32'd16);
    chk("clr_busy",   32'(n_busy), 32'd16);
    chk("clr_done",   32'(n_done), 32'd1);
    for (int i = 0; i < 16; i++) chk("clr_ram", 32'(ram[i]), 32'h0F00);

    // Reset in the middle of a fill with two writes queued.
    bus.clear_start = 1; bus.clear_color = 12'h0AA;
    step();
    bus.clear_start = 0;
    repeat (7) step();
    bus.rd_req = 1; bus.rd_addr = 16'h0010;
    bus.wr_valid = 1; bus.wr_addr = 16'h0005; bus.wr_data = 12'h555;
    step();
    bus.wr_addr = 16'h0006; bus.wr_data = 12'h666;
    step();
    idle_inputs();
    reset = 1'b1;
    model_reset();
    clear_counters();
    step();
    chk("mid_rst_busy",  32'(bus.clear_busy), 32'd0);
    chk("mid_rst_ready", 32'(bus.wr_ready),   32'd1);
    reset = 1'b0;
    repeat (20) step();
    chk("mid_rst_we",   32'(n_we),   32'd0);
    chk("mid_rst_done", 32'(n_done), 32'd0);
    chk("mid_rst_ram5", 32'(ram[5]), 32'h00AA);
    chk("mid_rst_ram7", 32'(ram[7]), 32'h0F00);

    // Random traffic; read requests are held until acknowledged.
    for (int n = 0; n < 600; n++) begin
      if (!(bus.rd_req && m_g != 1)) begin
        bus.rd_req  = ($urandom_range(0, 2) == 0);
        bus.rd_addr = 16'($urandom_range(0, 31));
      end
      bus.wr_valid    = ($urandom_range(0, 1) == 1);
      bus.wr_addr     = 16'($urandom_range(0, 31));
      bus.wr_data     = 12'($urandom);
      bus.clear_start = ($urandom_range(0, 79) == 0);
      bus.clear_color = 12'($urandom);
      step();
    end
    idle_inputs();
    repeat (40) step();
    chk("end_ready", 32'(bus.wr_ready),   32'd1);
    chk("end_busy",  32'(bus.clear_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
